// File: rtl/ysyx_25020047_pkg.sv
// Shared definitions for the ysyx_25020047 load/store path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ysyx_25020047_pkg;

  // Access size encodings carried on in_size; 2'd3 is illegal.
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Default number of WAIT_RSP cycles before an access is faulted.
  localparam int MEM_TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_DONE     = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/ysyx_25020047_lsu_align.sv
// Byte-lane steering: store strobe/data replication and load extract/extend.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
// Ports: addr_lo (byte offset), size, uns (zero-extend), store_data, rdata (load word)
//        -> wstrb, wdata (store lanes), load_data (extended load value).
module ysyx_25020047_lsu_align
  import ysyx_25020047_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  // Addressed byte/half moved down to bit 0; only the low half is ever needed.
  logic [15:0] sh;
  assign sh = 16'(rdata >> {addr_lo, 3'b000});

  always_comb begin
    wstrb     = 4'hF;
    wdata     = store_data;
    load_data = rdata;
    case (size)
      SZ_B: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = uns ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      end
      SZ_H: begin
        wstrb     = 4'b0011 << addr_lo;
        wdata     = {2{store_data[15:0]}};
        load_data = uns ? {16'b0, sh} : {{16{sh[15]}}, sh};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_25020047_lsu.sv
// Load/store unit: one instruction in flight, mem request/response, result to write-back.
// Latency: pass-through/fault 1 cycle; memory access >= 3 cycles (req, rsp, result).
// Backpressure: in_ready only in IDLE; req held until mem_req_ready; result held until out_ready.
// Ports: clk/rst (sync, active-high); in_* execute payload; mem_req_*/mem_rsp_* data-memory
//        port; out_* write-back payload with out_fault for misalign/size/bus error/timeout.
module ysyx_25020047_lsu
  import ysyx_25020047_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_result,
  input  logic [31:0] in_store_data,
  input  logic        in_read,
  input  logic        in_write,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_wen,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata,
  input  logic        mem_rsp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_reg_wen,
  output logic        out_fault
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  lsu_state_t  state_q, state_d;
  logic [31:0] addr_q, sdata_q;
  logic        is_read_q, is_write_q, uns_q, reg_wen_q;
  logic [1:0]  size_q;
  logic [4:0]  rd_q;
  logic [CW-1:0] cnt_q;
  logic [31:0] out_data_q;
  logic        out_fault_q, out_wen_q;

  logic        accept, is_mem, bad_access, timeout_hit;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata, al_load;

  assign accept      = in_valid && (state_q == ST_IDLE);
  assign is_mem      = in_read || in_write;
  // Byte accesses can never be misaligned; size 3 faults regardless of address.
  assign bad_access  = (in_size == 2'd3) ||
                       ((in_size == SZ_H) && in_result[0]) ||
                       ((in_size == SZ_W) && (in_result[1:0] != 2'b00));
  assign timeout_hit = (cnt_q == CW'(MEM_TIMEOUT - 1));

  ysyx_25020047_lsu_align u_align (
    .addr_lo    (addr_q[1:0]),
    .size       (size_q),
    .uns        (uns_q),
    .store_data (sdata_q),
    .rdata      (mem_rsp_rdata),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata),
    .load_data  (al_load)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (accept) state_d = (!is_mem || bad_access) ? ST_DONE : ST_REQ;
      ST_REQ:      if (mem_req_ready) state_d = ST_WAIT_RSP;
      // A response coinciding with the REQ handshake is never looked at.
      ST_WAIT_RSP: if (mem_rsp_valid || timeout_hit) state_d = ST_DONE;
      ST_DONE:     if (out_ready) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready      = (state_q == ST_IDLE);
    mem_req_valid = (state_q == ST_REQ);
    mem_req_wen   = (state_q == ST_REQ) && is_write_q;
    mem_req_wstrb = ((state_q == ST_REQ) && is_write_q) ? al_wstrb : 4'h0;
    mem_req_addr  = {addr_q[31:2], 2'b00};
    mem_req_wdata = al_wdata;
    out_valid     = (state_q == ST_DONE);
    out_data      = out_data_q;
    out_rd        = rd_q;
    out_reg_wen   = out_wen_q;
    out_fault     = out_fault_q;
  end

  // Capture registers, timeout counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      sdata_q     <= '0;
      is_read_q   <= 1'b0;
      is_write_q  <= 1'b0;
      uns_q       <= 1'b0;
      reg_wen_q   <= 1'b0;
      size_q      <= SZ_B;
      rd_q        <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_fault_q <= 1'b0;
      out_wen_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q      <= in_result;
        sdata_q     <= in_store_data;
        is_read_q   <= in_read;
        is_write_q  <= in_write;
        uns_q       <= in_unsigned;
        reg_wen_q   <= in_reg_wen;
        size_q      <= in_size;
        rd_q        <= in_rd;
        out_data_q  <= in_result;
        out_fault_q <= is_mem && bad_access;
        out_wen_q   <= in_reg_wen && !is_mem;
      end
      if (state_q == ST_REQ && mem_req_ready) cnt_q <= '0;
      if (state_q == ST_WAIT_RSP) begin
        if (mem_rsp_valid) begin
          out_data_q  <= is_write_q ? addr_q : al_load;
          out_fault_q <= mem_rsp_err;
          out_wen_q   <= reg_wen_q && is_read_q && !mem_rsp_err;
        end else if (timeout_hit) begin
          out_data_q  <= addr_q;
          out_fault_q <= 1'b1;
          out_wen_q   <= 1'b0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

endmodule
